// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// forwarding selects, FSM states and small op-decode helpers.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Ops that launch the iterative core.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // Any op that needs the unit (and therefore must wait while it is busy).
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative multiply/divide datapath. One bit per cycle for WIDTH
// cycles: right-shift shift-add multiply, or restoring division. The upper
// half of the accumulator holds HI (product high / remainder), the lower half
// holds LO (product low / quotient).
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               div_q, div_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  // Iteration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      div_q    <= div_d;
    end
  end

  // Load on start, then one multiply or divide step per active cycle.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    div_d    = div_q;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    if (kill) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      div_d    = is_div_op(op);
      if (is_div_op(op)) begin
        acc_d  = {{WIDTH{1'b0}}, a_mag};
        opnd_d = b_mag;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, b_mag};
        opnd_d = a_mag;
      end
    end else if (active_q) begin
      if (div_q) begin
        // Restoring step: keep the trial difference only if it did not borrow.
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign done   = active_q && (cnt_q == LAST);
  assign raw_hi = acc_q[2*WIDTH-1:WIDTH];
  assign raw_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_stage.sv
// EX-stage multiply/divide unit: operand forwarding, IDLE/RUN/FIX control,
// sign correction, HI/LO registers and the stall request to hazard control.
// Handshake: an op in md_op is consumed at a rising edge only when stall=0
// and flush=0; while stall=1 the issuing stages hold md_op and operands.
module ex_muldiv_stage
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [3:0]       md_op,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] md_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             prod_neg_q, prod_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0]   op_a, op_b, a_mag, b_mag, raw_hi, raw_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic               a_neg, b_neg, accept, core_done, core_kill;

  // Forwarding muxes; code 11 falls back to the register file.
  always_comb begin
    case (forward_a)
      FWD_WB:  op_a = wb_fwd;
      FWD_MEM: op_a = mem_fwd;
      default: op_a = read_data1;
    endcase
    case (forward_b)
      FWD_WB:  op_b = wb_fwd;
      FWD_MEM: op_b = mem_fwd;
      default: op_b = read_data2;
    endcase
  end

  assign a_neg     = is_signed_op(md_op) && op_a[WIDTH-1];
  assign b_neg     = is_signed_op(md_op) && op_b[WIDTH-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;
  assign accept    = (state_q == ST_IDLE) && !flush && is_start_op(md_op);
  // A divide by zero only needs one RUN cycle, so the core is stopped there.
  assign core_kill = flush || ((state_q == ST_RUN) && dz_q);

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .kill   (core_kill),
    .op     (md_op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (core_done),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo)
  );

  // State register plus HI/LO and the per-op sign/bookkeeping flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      a_raw_q    <= '0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_raw_q    <= a_raw_d;
      prod_neg_q <= prod_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_q      <= div_d;
      dz_q       <= dz_d;
    end
  end

  // Next-state: IDLE -> RUN on accept, RUN -> FIX after the last step
  // (or straight away for divide by zero), FIX -> IDLE; flush aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)                  state_d = ST_IDLE;
        else if (dz_q || core_done) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch op flags at accept; write HI/LO from MTHI/MTLO or from the FIX cycle.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_raw_d    = a_raw_q;
    prod_neg_d = prod_neg_q;
    rem_neg_d  = rem_neg_q;
    div_d      = div_q;
    dz_d       = dz_q;
    prod_fix   = prod_neg_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};

    if (accept) begin
      a_raw_d    = op_a;
      prod_neg_d = a_neg ^ b_neg;
      rem_neg_d  = a_neg;
      div_d      = is_div_op(md_op);
      dz_d       = is_div_op(md_op) && (op_b == '0);
    end

    if ((state_q == ST_IDLE) && !flush) begin
      if (md_op == MD_MTHI) hi_d = op_a;
      if (md_op == MD_MTLO) lo_d = op_a;
    end

    if ((state_q == ST_FIX) && !flush) begin
      if (div_q && dz_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else if (div_q) begin
        hi_d = rem_neg_q  ? -raw_hi : raw_hi;
        lo_d = prod_neg_q ? -raw_lo : raw_lo;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  // Outputs: busy covers RUN and FIX; MFHI/MFLO read the registers directly.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall     = busy && is_md_op(md_op) && !flush;
    md_result = '0;
    if (!busy) begin
      if (md_op == MD_MFHI) md_result = hi_q;
      if (md_op == MD_MFLO) md_result = lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
